// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32I/RV32M execute unit.
// Base ALU ops and all short-cut cases finish one cycle after accept.
// MUL*/DIV*/REM* run an iterative shift-add multiply or restoring divide
// over XLEN BUSY cycles. One operation is in flight at a time.
module alu_seq #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      code,
   input  logic [XLEN-1:0] rv1,
   input  logic [XLEN-1:0] rv2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rvout,
   output logic            out_err,
   output logic            busy
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Single-cycle RV32I result for a base op code.
   function automatic logic [XLEN-1:0] base_result(input logic [4:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
      logic [SW-1:0]   sh;
      logic [XLEN-1:0] r;
      sh = b[SW-1:0];
      case (op)
         5'b01000: r = a + b;
         5'b11000: r = a - b;
         5'b01001: r = a << sh;
         5'b01010: r = ($signed(a) < $signed(b)) ? ONE : ZERO;
         5'b01011: r = (a < b) ? ONE : ZERO;
         5'b01100: r = a ^ b;
         5'b01101: r = a >> sh;
         5'b11101: r = $unsigned($signed(a) >>> sh);
         5'b01110: r = a | b;
         5'b01111: r = a & b;
         default:  r = ZERO;
      endcase
      return r;
   endfunction

   // True when the low five code bits name a supported base op.
   function automatic logic base_valid(input logic [4:0] op);
      logic v;
      case (op)
         5'b01000, 5'b01001, 5'b01010, 5'b01011,
         5'b01100, 5'b01101, 5'b01110, 5'b01111,
         5'b11000, 5'b11101: v = 1'b1;
         default:            v = 1'b0;
      endcase
      return v;
   endfunction

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;      // product accumulator / remainder (low half)
   logic [2*XLEN-1:0]     mcand_q, mcand_d;  // shifting multiplicand / divisor (low half)
   logic [XLEN-1:0]       opb_q, opb_d;      // shifting multiplier / dividend-quotient
   logic [2:0]            mop_q, mop_d;
   logic                  neg_q, neg_d;      // product or quotient negated at the end
   logic                  rneg_q, rneg_d;    // remainder negated at the end
   logic [XLEN-1:0]       rvout_q, rvout_d;
   logic                  err_q, err_d;

   logic                  is_base_s, is_m_s;
   logic                  s1_s, s2_s, sign1_s, sign2_s;
   logic [XLEN-1:0]       mag1_s, mag2_s;
   logic                  div_zero_s, div_ovf_s;
   logic [XLEN-1:0]       special_s;
   logic [2*XLEN-1:0]     mul_acc_s, prod_s;
   logic [XLEN:0]         rem_sh_s;
   logic                  div_ge_s;
   logic [XLEN-1:0]       rem_new_s, quo_new_s, quo_res_s, rem_res_s;

   // Request decode, operand magnitudes and divide short-cuts at accept time.
   always_comb begin
      is_base_s  = (code[5] == 1'b0) && base_valid(code[4:0]);
      is_m_s     = ENABLE_M && (code[5:3] == 3'b101);
      // MULH, MULHSU and signed DIV/REM treat rv1 as signed; MULH and signed DIV/REM treat rv2 as signed.
      s1_s       = (code[2:0] == 3'b001) || (code[2:0] == 3'b010) || (code[2] && !code[0]);
      s2_s       = (code[2:0] == 3'b001) || (code[2] && !code[0]);
      sign1_s    = s1_s && rv1[XLEN-1];
      sign2_s    = s2_s && rv2[XLEN-1];
      mag1_s     = sign1_s ? -rv1 : rv1;
      mag2_s     = sign2_s ? -rv2 : rv2;
      div_zero_s = (rv2 == ZERO);
      div_ovf_s  = !code[0] && (rv1 == MIN_INT) && (rv2 == ONES);
      if (code[1]) begin
         special_s = div_zero_s ? rv1 : ZERO;
      end else begin
         special_s = div_zero_s ? ONES : MIN_INT;
      end
   end

   // One multiply or divide iteration, plus the sign fix-up of its outcome.
   always_comb begin
      mul_acc_s = opb_q[0] ? (acc_q + mcand_q) : acc_q;
      prod_s    = neg_q ? -mul_acc_s : mul_acc_s;
      rem_sh_s  = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
      div_ge_s  = (rem_sh_s >= {1'b0, mcand_q[XLEN-1:0]});
      if (div_ge_s) begin
         rem_new_s = XLEN'(rem_sh_s - {1'b0, mcand_q[XLEN-1:0]});
      end else begin
         rem_new_s = rem_sh_s[XLEN-1:0];
      end
      quo_new_s = {opb_q[XLEN-2:0], div_ge_s};
      quo_res_s = neg_q ? -quo_new_s : quo_new_s;
      rem_res_s = rneg_q ? -rem_new_s : rem_new_s;
   end

   // Next-state logic for the IDLE/BUSY/DONE controller and the datapath registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      opb_d   = opb_q;
      mop_d   = mop_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      rvout_d = rvout_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_DONE;
               err_d   = 1'b0;
               mop_d   = code[2:0];
               if (is_base_s) begin
                  rvout_d = base_result(code[4:0], rv1, rv2);
               end else if (is_m_s && code[2] && (div_zero_s || div_ovf_s)) begin
                  rvout_d = special_s;
               end else if (is_m_s) begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_INIT;
                  acc_d   = {2*XLEN{1'b0}};
                  neg_d   = sign1_s ^ sign2_s;
                  rneg_d  = sign1_s;
                  if (code[2]) begin
                     mcand_d = {ZERO, mag2_s};
                     opb_d   = mag1_s;
                  end else begin
                     mcand_d = {ZERO, mag1_s};
                     opb_d   = mag2_s;
                  end
               end else begin
                  rvout_d = ZERO;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (mop_q[2]) begin
               acc_d = {ZERO, rem_new_s};
               opb_d = quo_new_s;
            end else begin
               acc_d   = mul_acc_s;
               mcand_d = mcand_q << 1;
               opb_d   = opb_q >> 1;
            end
            if (cnt_q == CNT_ONE) begin
               state_d = ST_DONE;
               case (mop_q)
                  3'b000:                 rvout_d = prod_s[XLEN-1:0];
                  3'b001, 3'b010, 3'b011: rvout_d = prod_s[2*XLEN-1:XLEN];
                  3'b100, 3'b101:         rvout_d = quo_res_s;
                  3'b110, 3'b111:         rvout_d = rem_res_s;
                  default:                rvout_d = ZERO;
               endcase
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         acc_q   <= {2*XLEN{1'b0}};
         mcand_q <= {2*XLEN{1'b0}};
         opb_q   <= ZERO;
         mop_q   <= 3'b000;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         rvout_q <= ZERO;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         opb_q   <= opb_d;
         mop_q   <= mop_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         rvout_q <= rvout_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign rvout     = rvout_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
   localparam int XLEN = 32;

   localparam logic [5:0] C_ADD  = 6'b001000, C_SUB  = 6'b011000, C_SLL  = 6'b001001,
                          C_SLT  = 6'b001010, C_SLTU = 6'b001011, C_XOR  = 6'b001100,
                          C_SRL  = 6'b001101, C_SRA  = 6'b011101, C_OR   = 6'b001110,
                          C_AND  = 6'b001111, C_MUL  = 6'b101000, C_MULH = 6'b101001,
                          C_MULHSU = 6'b101010, C_MULHU = 6'b101011, C_DIV = 6'b101100,
                          C_DIVU = 6'b101101, C_REM  = 6'b101110, C_REMU = 6'b101111;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, out_err, busy;
   logic [5:0]  code;
   logic [31:0] rv1, rv2, rvout;
   logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_err, n_busy;
   logic [5:0]  n_code;
   logic [31:0] n_rv1, n_rv2, n_rvout;

   int n_checks = 0;
   int n_errors = 0;

   logic [5:0]  codes [18] = '{C_ADD, C_SUB, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_SRA, C_OR,
                               C_AND, C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
   logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

   always #5 clk = ~clk;

   alu_seq #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .code(code),
      .rv1(rv1), .rv2(rv2), .out_valid(out_valid), .out_ready(out_ready), .rvout(rvout),
      .out_err(out_err), .busy(busy)
   );

   alu_seq #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
      .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready), .code(n_code),
      .rv1(n_rv1), .rv2(n_rv2), .out_valid(n_out_valid), .out_ready(n_out_ready), .rvout(n_rvout),
      .out_err(n_out_err), .busy(n_busy)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkint(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: result, error flag and latency straight from the ISA arithmetic.
   function automatic void model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input bit en_m, output logic [31:0] r, output logic e, output int lat);
      int          sa, sb;
      longint      la, lb, lu, sp;
      logic [63:0] up;
      logic [4:0]  sh;
      sa = a;
      sb = b;
      sh = b[4:0];
      la = 64'(sa);
      lb = 64'(sb);
      lu = 64'(b);
      r = 32'h0;
      e = 1'b0;
      lat = 1;
      if (c[5] == 1'b0) begin
         case (c[4:0])
            5'b01000: r = a + b;
            5'b11000: r = a - b;
            5'b01001: r = a << sh;
            5'b01010: r = (sa < sb) ? 32'd1 : 32'd0;
            5'b01011: r = (a < b) ? 32'd1 : 32'd0;
            5'b01100: r = a ^ b;
            5'b01101: r = a >> sh;
            5'b11101: r = sa >>> sh;
            5'b01110: r = a | b;
            5'b01111: r = a & b;
            default:  e = 1'b1;
         endcase
      end else if (en_m && c[4:3] == 2'b01) begin
         lat = XLEN + 1;
         case (c[2:0])
            3'd0: begin sp = la * lb; r = sp[31:0]; end
            3'd1: begin sp = la * lb; r = sp[63:32]; end
            3'd2: begin sp = la * lu; r = sp[63:32]; end
            3'd3: begin up = 64'(a) * 64'(b); r = up[63:32]; end
            3'd4: begin
               if (b == 32'h0) begin r = 32'hFFFF_FFFF; lat = 1; end
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
               else r = sa / sb;
            end
            3'd5: begin
               if (b == 32'h0) begin r = 32'hFFFF_FFFF; lat = 1; end
               else r = a / b;
            end
            3'd6: begin
               if (b == 32'h0) begin r = a; lat = 1; end
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 32'h0; lat = 1; end
               else r = sa % sb;
            end
            default: begin
               if (b == 32'h0) begin r = a; lat = 1; end
               else r = a % b;
            end
         endcase
      end else begin
         e = 1'b1;
      end
   endfunction

   // Issue one op, check latency/result/error, optionally hold back-pressure, then retire it.
   task automatic run_op(input string tag, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         output logic [31:0] obs, output logic obs_e);
      logic [31:0] exp_r;
      logic        exp_e;
      int          exp_lat;
      int          lat;
      model(c, a, b, 1'b1, exp_r, exp_e, exp_lat);
      check1({tag, " in_ready"}, in_ready, 1'b1);
      code = c; rv1 = a; rv2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; code = 6'($urandom); rv1 = $urandom; rv2 = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         out_ready = 1'($urandom);
         rv1 = $urandom; rv2 = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      checkint({tag, " latency"}, lat, exp_lat);
      check32({tag, " rvout"}, rvout, exp_r);
      check1({tag, " out_err"}, out_err, exp_e);
      obs = rvout;
      obs_e = out_err;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; code = C_ADD; rv1 = $urandom; rv2 = $urandom;
         @(posedge clk); #1;
         check32({tag, " hold rvout"}, rvout, exp_r);
         check1({tag, " hold in_ready"}, in_ready, 1'b0);
         check1({tag, " hold out_valid"}, out_valid, 1'b1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check1({tag, " retired"}, out_valid, 1'b0);
   endtask

   initial begin
      logic [31:0] obs;
      logic        obs_e;
      logic [5:0]  rc;
      logic [31:0] ra, rb;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; code = 6'h0; rv1 = 32'h0; rv2 = 32'h0;
      n_in_valid = 1'b0; n_out_ready = 1'b0; n_code = 6'h0; n_rv1 = 32'h0; n_rv2 = 32'h0;
      #1;
      check1("reset in_ready", in_ready, 1'b1);
      check1("reset out_valid", out_valid, 1'b0);
      check1("reset busy", busy, 1'b0);
      check32("reset rvout", rvout, 32'h0);
      check1("reset out_err", out_err, 1'b0);
      @(negedge clk); reset = 1'b0;

      // Async reset in the middle of a DIVU.
      run_op("pre_add", C_ADD, 32'd1, 32'd2, 0, obs, obs_e);
      code = C_DIVU; rv1 = 32'd100; rv2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check1("divu busy", busy, 1'b1);
      repeat (5) @(posedge clk);
      #3; reset = 1'b1; #1;
      check1("midreset busy", busy, 1'b0);
      check1("midreset in_ready", in_ready, 1'b1);
      check1("midreset out_valid", out_valid, 1'b0);
      check32("midreset rvout", rvout, 32'h0);
      check1("midreset out_err", out_err, 1'b0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      check1("after reset idle", out_valid, 1'b0);
      run_op("add5_7", C_ADD, 32'd5, 32'd7, 0, obs, obs_e);
      check32("add5_7 spec", obs, 32'd12);

      // Base ops.
      run_op("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h1, 0, obs, obs_e);
      check32("add_wrap spec", obs, 32'h0);
      run_op("sra", C_SRA, 32'h8000_0000, 32'd4, 0, obs, obs_e);
      check32("sra spec", obs, 32'hF800_0000);
      run_op("slt", C_SLT, 32'hFFFF_FFFF, 32'd1, 0, obs, obs_e);
      check32("slt spec", obs, 32'd1);
      run_op("sltu", C_SLTU, 32'hFFFF_FFFF, 32'd1, 0, obs, obs_e);
      check32("sltu spec", obs, 32'd0);

      // Multiplies.
      run_op("mulh", C_MULH, 32'h8000_0000, 32'h8000_0000, 0, obs, obs_e);
      check32("mulh spec", obs, 32'h4000_0000);
      run_op("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, obs, obs_e);
      check32("mulhu spec", obs, 32'hFFFF_FFFE);

      // Divides and special cases.
      run_op("div", C_DIV, 32'hFFFF_FFF9, 32'd2, 0, obs, obs_e);
      check32("div spec", obs, 32'hFFFF_FFFD);
      run_op("rem", C_REM, 32'hFFFF_FFF9, 32'd2, 0, obs, obs_e);
      check32("rem spec", obs, 32'hFFFF_FFFF);
      run_op("divu0", C_DIVU, 32'd7, 32'd0, 0, obs, obs_e);
      check32("divu0 spec", obs, 32'hFFFF_FFFF);
      run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, obs, obs_e);
      check32("div_ovf spec", obs, 32'h8000_0000);

      // Back-pressure with requests presented while the result waits.
      run_op("backpress", C_SUB, 32'd3, 32'd10, 10, obs, obs_e);
      check32("backpress spec", obs, 32'hFFFF_FFF9);

      // Invalid code.
      run_op("badcode", 6'b000000, 32'h1234_5678, 32'h1, 0, obs, obs_e);
      check1("badcode spec err", obs_e, 1'b1);
      check32("badcode spec rvout", obs, 32'h0);

      // Build without the M extension rejects MUL in one cycle.
      n_code = C_MUL; n_rv1 = 32'd3; n_rv2 = 32'd4; n_in_valid = 1'b1;
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      check1("nm out_valid", n_out_valid, 1'b1);
      check1("nm out_err", n_out_err, 1'b1);
      check32("nm rvout", n_rvout, 32'h0);
      n_out_ready = 1'b1;
      @(posedge clk); #1;
      n_out_ready = 1'b0;
      check1("nm retired", n_out_valid, 1'b0);

      // Random operations.
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) < 8) rc = codes[$urandom_range(0, 17)];
         else rc = 6'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         run_op($sformatf("rand%0d_c%02h", k, rc), rc, ra, rb, $urandom_range(0, 2), obs, obs_e);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
